// File: rtl/card_read_seq.sv
// Card-read sequencer: feeds reader columns through an external hole-to-EBCDIC
// converter and queues the bytes for the channel. Optional CARD_VALIDITY_CHECK_EN
// enables invalid-punch flagging (o_check / o_check_col).
//
// state | meaning
// IDLE  | waiting for i_start
// FEED  | accepting column strobes until NCOLS columns seen
// DRAIN | waiting for converter pipeline and FIFO to empty
// DONE  | one-cycle o_done pulse, then back to IDLE
module card_read_seq #(
    parameter int NCOLS      = 80,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_col_valid,
    input  logic [11:0] i_holes,
    output logic [11:0] o_cvt_holes,
    input  logic [7:0]  i_cvt_ebcdic,
    input  logic        i_cvt_bad,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overrun,
    output logic [7:0]  o_col_count,
    output logic        o_check,
    output logic [7:0]  o_check_col
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    state_t        state_q;
    logic [1:0]    rst_sync_q;
    logic          rst_n_int;
    logic [11:0]   cvt_holes_q;
    logic          s1_q, s2_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   occ_q, occ_d;
    logic [AW+1:0] used;
    logic          busy_q, done_q, overrun_q;
    logic [7:0]    col_count_q, col_count_inc;
    logic          push, pop, strobe, accept;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) rst_sync_q <= 2'b00;
        else            rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    always_comb begin
        push          = s2_q;
        pop           = (occ_q != '0) && i_ready;
        occ_d         = occ_q + (AW+1)'(push) - (AW+1)'(pop);
        used          = {1'b0, occ_q} + (AW+2)'(s1_q) + (AW+2)'(s2_q);
        strobe        = (state_q == FEED) && i_col_valid;
        accept        = strobe && (used < (AW+2)'(FIFO_DEPTH));
        col_count_inc = (col_count_q == 8'(NCOLS)) ? col_count_q : col_count_q + 8'd1;
    end

`ifdef CARD_VALIDITY_CHECK_EN
    logic       check_q;
    logic [7:0] check_col_q;
    logic [7:0] col_s1_q, col_s2_q;
    assign o_check     = check_q;
    assign o_check_col = check_col_q;
`else
    logic unused_cvt_bad;
    assign unused_cvt_bad = i_cvt_bad;
    assign o_check        = 1'b0;
    assign o_check_col    = 8'd0;
`endif

    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= IDLE;
            cvt_holes_q <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            col_count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef CARD_VALIDITY_CHECK_EN
            check_q     <= 1'b0;
            check_col_q <= '0;
            col_s1_q    <= '0;
            col_s2_q    <= '0;
`endif
        end else if (i_abort) begin
            // Flush by snapping the write pointer to the read pointer so o_data holds.
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            wr_ptr_q <= rd_ptr_q;
            occ_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            s1_q   <= accept;
            s2_q   <= s1_q;
            occ_q  <= occ_d;
            if (accept) cvt_holes_q <= i_holes;
            if (push) begin
                mem_q[wr_ptr_q] <= i_cvt_ebcdic;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef CARD_VALIDITY_CHECK_EN
            if (accept) col_s1_q <= col_count_q + 8'd1;
            col_s2_q <= col_s1_q;
            if (push && i_cvt_bad) begin
                check_q <= 1'b1;
                if (!check_q) check_col_q <= col_s2_q;
            end
`endif
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q     <= FEED;
                        busy_q      <= 1'b1;
                        col_count_q <= '0;
                        overrun_q   <= 1'b0;
                        s1_q        <= 1'b0;
                        s2_q        <= 1'b0;
`ifdef CARD_VALIDITY_CHECK_EN
                        check_q     <= 1'b0;
                        check_col_q <= '0;
`endif
                    end
                end
                FEED: begin
                    if (strobe) begin
                        col_count_q <= col_count_inc;
                        if (!accept) overrun_q <= 1'b1;
                        if (col_count_inc == 8'(NCOLS)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s1_q && !s2_q && occ_d == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_cvt_holes = cvt_holes_q;
    assign o_data      = mem_q[rd_ptr_q];
    assign o_valid     = (occ_q != '0);
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_overrun   = overrun_q;
    assign o_col_count = col_count_q;
endmodule

// File: tb/tb_card_read_seq.sv
// Scoreboard bench for card_read_seq: directed cards with hand-computed bytes,
// a behavioural hole-to-EBCDIC converter, and a FIFO-side monitor.
module tb_card_read_seq;
    logic        clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0, i_abort = 1'b0, i_col_valid = 1'b0, i_ready = 1'b0;
    logic [11:0] i_holes = '0;
    logic [11:0] o_cvt_holes;
    logic [7:0]  cvt_ebcdic = '0;
    logic        cvt_bad = 1'b0;
    logic [7:0]  o_data, o_col_count, o_check_col;
    logic        o_valid, o_busy, o_done, o_overrun, o_check;

    int checks = 0, errors = 0, pops = 0, done_cnt = 0;
    logic [7:0] exp_q[$];
    logic [8:0] cvt_r;

    logic [11:0] vh [10] = '{12'h900, 12'h500, 12'h240, 12'h001, 12'h800,
                             12'h400, 12'h200, 12'h880, 12'h401, 12'h000};
    logic [7:0]  vb [10] = '{8'hC1, 8'hD1, 8'hE3, 8'hF9, 8'h50,
                             8'h60, 8'hF0, 8'hC2, 8'hD9, 8'h40};

    always #5 clk = ~clk;

    card_read_seq #(.NCOLS(80), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_abort(i_abort),
        .i_col_valid(i_col_valid), .i_holes(i_holes), .o_cvt_holes(o_cvt_holes),
        .i_cvt_ebcdic(cvt_ebcdic), .i_cvt_bad(cvt_bad), .o_data(o_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done),
        .o_overrun(o_overrun), .o_col_count(o_col_count), .o_check(o_check),
        .o_check_col(o_check_col));

    // Behavioural converter: {bad, byte}; unrecognised punches give bad with 0x3F.
    function automatic logic [8:0] cvt(input logic [11:0] h);
        int nd = 0;
        int d  = 0;
        logic [2:0] zone;
        zone = h[11:9];
        for (int r = 1; r <= 9; r++) if (h[9-r]) begin nd++; d = r; end
        if (h == 12'h000) return {1'b0, 8'h40};
        if (nd == 0) begin
            case (zone)
                3'b100:  return {1'b0, 8'h50};
                3'b010:  return {1'b0, 8'h60};
                3'b001:  return {1'b0, 8'hF0};
                default: return {1'b1, 8'h3F};
            endcase
        end
        if (nd == 1) begin
            case (zone)
                3'b000:  return {1'b0, 8'hF0 + 8'(d)};
                3'b100:  return {1'b0, 8'hC0 + 8'(d)};
                3'b010:  return {1'b0, 8'hD0 + 8'(d)};
                3'b001:  if (d >= 2) return {1'b0, 8'hE0 + 8'(d)};
                default: return {1'b1, 8'h3F};
            endcase
        end
        return {1'b1, 8'h3F};
    endfunction

    always @(posedge clk) begin
        cvt_r      = cvt(o_cvt_holes);
        cvt_ebcdic <= cvt_r[7:0];
        cvt_bad    <= cvt_r[8];
    end

    // Monitor: every accepted byte is compared against the scoreboard head.
    always @(negedge clk) begin
        logic [7:0] e;
        if (o_done) done_cnt++;
        if (o_valid && i_ready) begin
            pops++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL byte_unexpected got %02h expected none", o_data);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    errors++;
                    $display("FAIL byte got %02h expected %02h", o_data, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [11:0] h, input logic [7:0] b, input bit push);
        i_col_valid = 1'b1;
        i_holes     = h;
        if (push) exp_q.push_back(b);
        cyc(1);
        i_col_valid = 1'b0;
    endtask

    task automatic start_card();
        i_start = 1'b1;
        cyc(1);
        i_start = 1'b0;
        chk("busy_after_start", o_busy, 1);
    endtask

    task automatic wait_done(input string nm);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
            n++;
        end
        chk(nm, seen, 1);
        cyc(1);
        chk({nm, "_pulse_end"}, o_done, 0);
        chk({nm, "_idle"}, o_busy, 0);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_cvt_holes"}, o_cvt_holes, 0);
        chk({nm, "_data"},      o_data, 0);
        chk({nm, "_valid"},     o_valid, 0);
        chk({nm, "_busy"},      o_busy, 0);
        chk({nm, "_done"},      o_done, 0);
        chk({nm, "_overrun"},   o_overrun, 0);
        chk({nm, "_col_count"}, o_col_count, 0);
        chk({nm, "_check"},     o_check, 0);
        chk({nm, "_check_col"}, o_check_col, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        int pops0, done0;
        cyc(3);
        check_reset_vals("rst");
        i_reset_n = 1'b1;
        cyc(4);

        // Blank card, back-to-back strobes with the channel always ready.
        i_ready = 1'b1;
        start_card();
        for (int i = 0; i < 80; i++) strobe(12'h000, 8'h40, 1'b1);
        wait_done("blank_done");
        chk("blank_done_cnt", done_cnt, 1);
        chk("blank_cols", o_col_count, 80);
        chk("blank_overrun", o_overrun, 0);
        chk("blank_drained", exp_q.size(), 0);

        // Latency of a single 'A' column.
        i_ready = 1'b0;
        start_card();
        cyc(2);
        strobe(12'h900, 8'hC1, 1'b1);
        chk("lat_cycle1", o_valid, 0);
        cyc(1);
        chk("lat_cycle2", o_valid, 0);
        cyc(1);
        chk("lat_cycle3", o_valid, 1);
        chk("lat_data", o_data, 8'hC1);
        i_ready = 1'b1;

        // Columns 2..7, column 7 carries an invalid punch.
        strobe(12'h500, 8'hD1, 1'b1);
        strobe(12'h240, 8'hE3, 1'b1);
        strobe(12'h001, 8'hF9, 1'b1);
        strobe(12'h800, 8'h50, 1'b1);
        strobe(12'h200, 8'hF0, 1'b1);
        strobe(12'h180, 8'h3F, 1'b1);
        cyc(6);
        chk("col7_count", o_col_count, 7);
`ifdef CARD_VALIDITY_CHECK_EN
        chk("bad_check", o_check, 1);
        chk("bad_check_col", o_check_col, 7);
`else
        chk("bad_check", o_check, 0);
        chk("bad_check_col", o_check_col, 0);
`endif

        // Backpressure: five strobes into a stalled four-entry FIFO.
        i_ready = 1'b0;
        strobe(12'h100, 8'hF1, 1'b1);
        strobe(12'h080, 8'hF2, 1'b1);
        strobe(12'h040, 8'hF3, 1'b1);
        strobe(12'h020, 8'hF4, 1'b1);
        chk("bp_no_overrun_yet", o_overrun, 0);
        strobe(12'h010, 8'hF5, 1'b0);
        chk("bp_overrun", o_overrun, 1);
        chk("bp_col_count", o_col_count, 12);
        cyc(4);
        chk("bp_valid_held", o_valid, 1);
        pops0   = pops;
        i_ready = 1'b1;
        cyc(10);
        chk("bp_delivered", pops - pops0, 4);
        chk("bp_drained", exp_q.size(), 0);

        // Abort with three bytes queued.
        i_ready = 1'b0;
        strobe(12'h008, 8'hF6, 1'b0);
        strobe(12'h004, 8'hF7, 1'b0);
        strobe(12'h002, 8'hF8, 1'b0);
        cyc(4);
        chk("abort_pre_valid", o_valid, 1);
        done0   = done_cnt;
        i_abort = 1'b1;
        cyc(1);
        i_abort = 1'b0;
        chk("abort_valid", o_valid, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_col_count", o_col_count, 15);
        chk("abort_overrun_held", o_overrun, 1);
        i_ready = 1'b1;
        cyc(6);
        chk("abort_no_done", done_cnt - done0, 0);

        // New card after abort, then asynchronous reset mid-card.
        start_card();
        chk("restart_cols", o_col_count, 0);
        chk("restart_overrun", o_overrun, 0);
        chk("restart_check", o_check, 0);
        for (int i = 0; i < 10; i++) strobe(12'h000, 8'h40, 1'b1);
        #2;
        i_reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_vals("midrst");
        cyc(2);
        i_reset_n = 1'b1;
        cyc(4);
        check_reset_vals("post_rst");

        // Full card of mixed characters after reset.
        done0 = done_cnt;
        start_card();
        for (int i = 0; i < 80; i++) strobe(vh[i % 10], vb[i % 10], 1'b1);
        wait_done("mixed_done");
        chk("mixed_done_cnt", done_cnt - done0, 1);
        chk("mixed_cols", o_col_count, 80);
        chk("mixed_overrun", o_overrun, 0);
        chk("mixed_drained", exp_q.size(), 0);
        chk("mixed_check", o_check, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/card_read_seq.md
# card_read_seq

Card-read sequencer for the 2821 card path. On a start command it accepts one card image column-by-column from the reader front end and drives each 12-bit hole pattern through the registered hole-to-EBCDIC converter. It queues the converted bytes in a small FIFO and hands them to the channel side over a valid/ready handshake. It also counts columns, flags overrun, and signals end of card.

## Interface
Parameters:
- NCOLS, 80: columns per card; legal range 1..255.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two, minimum 2.

Ports:
- i_clk  in  1  system clock; all state changes on the rising edge.
- i_reset_n  in  1  asynchronous, active-low reset. Asserts immediately; deassertion is synchronous to i_clk.
- i_start  in  1  one-cycle pulse; begins a card. Ignored unless in IDLE.
- i_abort  in  1  one-cycle pulse; returns to IDLE from any state.
- i_col_valid  in  1  reader column strobe; one-cycle pulse, cannot be stalled.
- i_holes  in  12  column holes, bit 11 = row 12 … bit 0 = row 9.
- o_cvt_holes  out  12  holes presented to the converter (registered).
- i_cvt_ebcdic  in  8  converter output; valid one cycle after o_cvt_holes.
- i_cvt_bad  in  1  converter invalid-punch flag, same timing as i_cvt_ebcdic.
- o_data  out  8  FIFO head byte.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  channel accepts o_data when o_valid && i_ready.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when the card is complete and drained.
- o_overrun  out  1  sticky; a column was dropped. Cleared by i_start.
- o_col_count  out  8  columns accepted this card.
- o_check  out  1  sticky invalid-punch flag; see Configuration.
- o_check_col  out  8  1-based column of the first invalid punch.

## Operation
States: IDLE, FEED, DRAIN, DONE.
- **IDLE:** i_start clears o_col_count, o_overrun, o_check, o_check_col and the pipeline, then goes to FEED.
- **FEED:** on i_col_valid:
  - Column is accepted if FIFO occupancy + in-flight columns < FIFO_DEPTH.
  - On accept, latch i_holes into o_cvt_holes and increment o_col_count.
  - Otherwise drop the column and set o_overrun; o_col_count still increments, so the card position stays correct.
- **FEED → DRAIN:** when o_col_count reaches NCOLS.
- **DRAIN:** wait until the pipeline and the FIFO are both empty, then go to DONE.
- **DONE:** assert o_done for one cycle, then go to IDLE.
- **In-flight tracking:** a 2-stage valid shift register.
  - Stage 1 = o_cvt_holes valid.
  - Stage 2 = converter output valid; at stage 2, i_cvt_ebcdic is written to the FIFO.
- **Simultaneous events:**
  - A FIFO push and pop in the same cycle leave occupancy unchanged.
  - i_col_valid outside FEED is ignored and does not set o_overrun.
  - i_abort has priority over every other event: state goes to IDLE, the FIFO and pipeline are flushed, and o_valid drops the next cycle. Sticky flags and o_col_count hold their values until the next i_start.
- **Counter widths:**
  - FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Occupancy is log2(FIFO_DEPTH)+1 bits.
  - o_col_count saturates at NCOLS.

## Timing
- **Reset values:** state IDLE; o_cvt_holes 0; o_data 0; o_valid 0; o_busy 0; o_done 0; o_overrun 0; o_col_count 0; o_check 0; o_check_col 0.
- **Column latency:** i_col_valid at edge t → o_cvt_holes valid in cycle t+1 → converter output sampled at edge t+2 → o_valid high in cycle t+3 (FIFO previously empty).
- **Throughput:** back-to-back columns are accepted at one per cycle, subject to the space check.
- **Handshake:**
  - o_data changes only after a pop or when the FIFO goes from empty to non-empty.
  - o_valid never drops without a pop, except on abort or reset.
- **Start/busy:** i_start in IDLE raises o_busy the following cycle.
- **Done:** o_done is asserted the cycle after the last byte is popped.
- **Reset mid-card:** immediate return to the reset values above; no partial byte is delivered.

## Configuration
- **Macro:** CARD_VALIDITY_CHECK_EN.
- **Defined:**
  - i_cvt_bad at pipeline stage 2 sets o_check.
  - On the first such event per card, the 1-based column number is captured in o_check_col.
  - The byte is still queued.
- **Undefined:** i_cvt_bad is ignored, and o_check and o_check_col are tied to 0.

## Test plan
- **Blank card:** start, 80 strobes of i_holes=0x000, i_ready=1 → 80 bytes of 0x40, o_done once, o_col_count=80, o_overrun=0.
- **Latency and 'A':** one column 0x900 → o_valid rises exactly 3 cycles after the strobe with o_data=0xC1.
- **Backpressure:** FIFO_DEPTH=4, i_ready=0, 5 consecutive strobes → first 4 queued, o_overrun=1 at the 5th, o_col_count=5; raise i_ready → exactly 4 bytes delivered.
- **Invalid punch (macro defined):** column 7 = 0x180 → o_check=1, o_check_col=7, byte still delivered. With the macro undefined, o_check stays 0.
- **Abort:** abort mid-card with 3 bytes queued → o_valid=0 next cycle, state IDLE, no o_done pulse; a new i_start then works normally.
- **Reset mid-card:** drop i_reset_n asynchronously mid-card → all outputs at reset values within the same cycle; after release, i_start runs a full card correctly.
